// File: rtl/arbitro_rr_pkg.sv
// Shared constants for the round-robin read arbiter: FSM encoding, port count
// and the position of the destination field inside a data word.
package arbitro_rr_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DEST_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Destination field sits in the top DEST_W bits of the word.
  function automatic int dest_lsb(input int data_width);
    return data_width - DEST_W;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests so the slot after last is at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick
  import arbitro_rr_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           last,
  output logic [1:0]           gnt_idx,
  output logic                 any
);

  logic [1:0]             start;
  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [1:0]             off;

  assign start = last + 2'd1;
  assign dbl   = {req, req};
  assign rot   = dbl[start +: NUM_PORTS];

  always_comb begin
    off = 2'd0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) off = 2'(k);
    end
  end

  assign gnt_idx = start + off;
  assign any     = |req;

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin reader of four input FIFOs: pop -> registered FIFO read -> push
// to the destination named by the word's top two bits; stalls on any almost-full.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int data_width = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*data_width-1:0] fifo_data,
  input  logic [NUM_PORTS-1:0]            down_almost_full,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [NUM_PORTS-1:0]            push,
  output logic [data_width-1:0]           data_out,
  output logic                            idle
);

  state_t              state;
  state_t              nxt_state;
  logic [1:0]          last_grant;
  logic [1:0]          gnt;
  logic                any_req;
  logic                valid1;
  logic [1:0]          sel1;
  logic [data_width-1:0] word;
  logic [DEST_W-1:0]   dest;

  rr_pick u_pick (
    .req     (~fifo_empty),
    .last    (last_grant),
    .gnt_idx (gnt),
    .any     (any_req)
  );

  always_comb begin
    if (|down_almost_full) nxt_state = ST_STALL;
    else if (!any_req)     nxt_state = ST_IDLE;
    else                   nxt_state = ST_RUN;
  end

  // Pop follows this cycle's flags directly so a stall bites immediately and
  // a release resumes without a bubble.
  assign pop  = (reset && nxt_state == ST_RUN) ? (4'b0001 << gnt) : 4'b0000;

  assign word = fifo_data[sel1*data_width +: data_width];
  assign dest = word[dest_lsb(data_width) +: DEST_W];
  assign idle = (state == ST_IDLE) && !valid1 && (push == 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= 2'd3;
      valid1     <= 1'b0;
      sel1       <= 2'd0;
      push       <= '0;
      data_out   <= '0;
    end else begin
      state  <= nxt_state;
      valid1 <= |pop;
      if (|pop) begin
        sel1       <= gnt;
        last_grant <= gnt;
      end
      // Words already popped always complete, even into an almost-full target.
      if (valid1) begin
        push     <= 4'b0001 << dest;
        data_out <= word;
      end else begin
        push <= '0;
      end
    end
  end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Round-robin read arbiter sitting directly downstream of the four class input FIFOs (10-bit words, 8-bit address) and upstream of the four destination FIFOs. Pops one word per cycle from the next non-empty input FIFO and routes it, one push wide, to the destination FIFO selected by the word's two MSBs. Throttles all reads whenever any destination FIFO reports almost-full.

## Interface
- data_width, 10, word width. Destination field is bits [data_width-1:data_width-2].
- Number of ports is fixed at 4 and is not a parameter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- fifo_empty  in  4  empty flag of input FIFO i, bit i.
- fifo_data  in  4*data_width  data_out of input FIFO i at bits [i*data_width +: data_width].
- down_almost_full  in  4  almost-full flag of destination FIFO j, bit j.
- pop  out  4  one-hot or zero; pop strobe to input FIFO i.
- push  out  4  one-hot or zero; push strobe to destination FIFO j.
- data_out  out  data_width  word presented with push, shared by all destination FIFOs.
- idle  out  1  high when there is no pending work: nothing in flight and no input FIFO non-empty.

## Operation
- Input FIFO read timing: pop in cycle N gives valid fifo_data in cycle N+1 (registered read).

States (2-bit):
- IDLE: all fifo_empty=1.
- RUN: issuing pops.
- STALL: any down_almost_full=1.

Transitions, evaluated every cycle, with this priority:
- Any down_almost_full → STALL.
- Otherwise, all empty → IDLE.
- Otherwise → RUN.

Grant rule in RUN:
- grant = first i with fifo_empty[i]=0, searching from (last_grant+1) mod 4 upward with wrap.
- pop[grant]=1 for that cycle, then last_grant←grant.
- No pops in IDLE or STALL.

Pipeline:
- Stage 1 registers valid1 and sel1=grant alongside the pop.
- Stage 2, in the cycle after the pop: word = fifo_data[sel1] is sampled; data_out←word, push[word[MSB:MSB-1]]←1, and all other push bits ←0.
- push and data_out are registered outputs.

Other rules:
- Back-to-back pops: allowed every cycle, including from the same FIFO if it is the only non-empty one.
- Backpressure: entering STALL suppresses only new pops. Up to 2 words already in flight still complete their push. Downstream almost-full thresholds must leave ≥2 free slots.
- idle = (state==IDLE) && !valid1 && !push-pending.

## Timing
- Reset values: pop=0, push=0, data_out=0, idle=1, state=IDLE, last_grant=3 (so the first grant goes to FIFO 0), valid1=0.
- Latency: pop at edge-cycle N → push and data_out valid in cycle N+2. Steady-state throughput is 1 word/cycle.
- pop is combinational from state, fifo_empty, down_almost_full and last_grant. It is gated low while reset=0.
- down_almost_full asserting in cycle N: no pop in N. The word popped in N-1 still pushes in N+1.
- Simultaneous down_almost_full deassert and fifo becoming non-empty: pop in that same cycle.
- Reset mid-operation: in-flight words are discarded, with no push after reset deasserts until a new pop is issued. Lost words are acceptable; the input FIFOs are reset together with this block.
- Words for any destination are pushed even if that destination is almost-full. The almost-full margin covers this.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, STALL=2)
  - NUM_PORTS=4
  - destination field offset/width constants
  - these are shared with the demux and testbench.
- Sub-module rr_pick (combinational): inputs req[3:0] and last[1:0]; outputs gnt_idx[1:0] and any. It rotates, priority-encodes and rotates back.
- Top level holds the FSM, last_grant, the 2-stage pipeline and the output registers.

## Test plan
- Reset: hold reset=0 with random inputs → pop=0, push=0, data_out=0, idle=1. Release with all empty → idle stays 1, no pops.
- Single word: FIFO 2 holds 10'b11_0000_0101 → pop=4'b0100 in cycle N; push=4'b1000 and data_out=0x305 in N+2; idle returns to 1.
- Round-robin: all four FIFOs each hold 3 words → pop sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; 12 pushes in order, each to the destination in its word bits [9:8].
- Skip empties: only FIFOs 1 and 3 are non-empty (2 words each) → pops 1,3,1,3 with no gap cycles.
- Backpressure: down_almost_full[0]=1 in cycle N during streaming → no pop in N.., exactly the 2 in-flight words still pushed, pops resume the cycle after deassert with the next round-robin index.
- Reset mid-stream: reset=0 one cycle after a pop → push never asserts for that word; after release the first grant goes to FIFO 0.
